// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: takes one access from the EX/MEM register and
// issues it on a valid/ready data-memory bus. For a load it then waits for the
// read response and returns the lane-aligned, extended result. The pipeline is
// stalled while an access is in flight.
module mem_access_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            regM_i_valid,
   input  logic [10:0]     regM_i_load_store_info,
   input  logic [XLEN-1:0] regM_i_alu_result,
   input  logic [XLEN-1:0] regM_i_regdata2,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic [XLEN-1:0] dmem_req_addr,
   output logic            dmem_req_wen,
   output logic [XLEN-1:0] dmem_req_wdata,
   output logic [7:0]      dmem_req_wstrb,
   input  logic            dmem_resp_valid,
   input  logic [XLEN-1:0] dmem_resp_rdata,
   output logic [XLEN-1:0] memory_o_rdata,
   output logic            memory_o_done,
   output logic            memory_o_stall,
   output logic            memory_o_misalign
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]      state_reg, state_next;
   logic [6:0]      ld_op_reg;      // one-hot load kind, bits [6:0] of info
   logic [2:0]      off_reg;        // byte offset inside the 8-byte word
   logic [XLEN-1:0] addr_reg;
   logic            wen_reg;
   logic [XLEN-1:0] wdata_reg;
   logic [7:0]      wstrb_reg;
   logic [XLEN-1:0] rdata_reg;
   logic            misalign_reg;

   logic            mem_op;
   logic            misaligned;
   logic            go_req;
   logic [2:0]      off;
   logic [7:0]      strb_base;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_ext;

   // Decode the incoming op: presence, alignment and base write strobe
   always_comb begin
      off        = regM_i_alu_result[2:0];
      mem_op     = regM_i_valid & (|regM_i_load_store_info);
      misaligned = ((regM_i_load_store_info[1] | regM_i_load_store_info[5] |
                     regM_i_load_store_info[8]) & off[0]) |
                   ((regM_i_load_store_info[2] | regM_i_load_store_info[6] |
                     regM_i_load_store_info[9]) & (|off[1:0])) |
                   ((regM_i_load_store_info[3] | regM_i_load_store_info[10]) & (|off));
      go_req     = mem_op & ~misaligned;
      strb_base  = 8'h00;
      if (regM_i_load_store_info[7])  strb_base = 8'h01;
      if (regM_i_load_store_info[8])  strb_base = 8'h03;
      if (regM_i_load_store_info[9])  strb_base = 8'h0F;
      if (regM_i_load_store_info[10]) strb_base = 8'hFF;
   end

   // Next-state logic; responses only count while waiting in RESP
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (go_req)          state_next = ST_REQ;
         ST_REQ:  if (dmem_req_ready)  state_next = wen_reg ? ST_DONE : ST_RESP;
         ST_RESP: if (dmem_resp_valid) state_next = ST_DONE;
         default:                      state_next = ST_IDLE;
      endcase
   end

   // Bring the addressed bytes down to bit 0 and extend per load kind
   always_comb begin
      shifted  = dmem_resp_rdata >> {off_reg, 3'b000};
      load_ext = shifted;
      if (ld_op_reg[0]) load_ext = {{56{shifted[7]}},  shifted[7:0]};
      if (ld_op_reg[1]) load_ext = {{48{shifted[15]}}, shifted[15:0]};
      if (ld_op_reg[2]) load_ext = {{32{shifted[31]}}, shifted[31:0]};
      if (ld_op_reg[4]) load_ext = {56'd0, shifted[7:0]};
      if (ld_op_reg[5]) load_ext = {48'd0, shifted[15:0]};
      if (ld_op_reg[6]) load_ext = {32'd0, shifted[31:0]};
   end

   // State, latched request fields, load result and misalign pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         ld_op_reg    <= '0;
         off_reg      <= '0;
         addr_reg     <= '0;
         wen_reg      <= 1'b0;
         wdata_reg    <= '0;
         wstrb_reg    <= '0;
         rdata_reg    <= '0;
         misalign_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         misalign_reg <= (state_reg == ST_IDLE) & mem_op & misaligned;
         if (state_reg == ST_IDLE && go_req) begin
            ld_op_reg <= regM_i_load_store_info[6:0];
            off_reg   <= off;
            addr_reg  <= {regM_i_alu_result[XLEN-1:3], 3'b000};
            wen_reg   <= |regM_i_load_store_info[10:7];
            wdata_reg <= regM_i_regdata2 << {off, 3'b000};
            wstrb_reg <= strb_base << off;
         end
         if (state_reg == ST_RESP && dmem_resp_valid)
            rdata_reg <= load_ext;
      end
   end

   assign dmem_req_valid    = (state_reg == ST_REQ);
   assign dmem_req_addr     = addr_reg;
   assign dmem_req_wen      = wen_reg;
   assign dmem_req_wdata    = wdata_reg;
   assign dmem_req_wstrb    = wstrb_reg;
   assign memory_o_rdata    = rdata_reg;
   assign memory_o_done     = (state_reg == ST_DONE);
   assign memory_o_misalign = misalign_reg;
   assign memory_o_stall    = (state_reg == ST_REQ) | (state_reg == ST_RESP) |
                              ((state_reg == ST_IDLE) & go_req);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard of expected accesses.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        regM_i_valid;
   logic [10:0] regM_i_load_store_info;
   logic [63:0] regM_i_alu_result;
   logic [63:0] regM_i_regdata2;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [63:0] dmem_req_addr;
   logic        dmem_req_wen;
   logic [63:0] dmem_req_wdata;
   logic [7:0]  dmem_req_wstrb;
   logic        dmem_resp_valid;
   logic [63:0] dmem_resp_rdata;
   logic [63:0] memory_o_rdata;
   logic        memory_o_done;
   logic        memory_o_stall;
   logic        memory_o_misalign;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic [63:0] rdata;
      int          lat;
   } exp_t;
   exp_t exp_q[$];

   localparam int OP_LB = 0, OP_LH = 1, OP_LW = 2, OP_LD = 3, OP_LBU = 4, OP_LHU = 5,
                  OP_LWU = 6, OP_SB = 7, OP_SH = 8, OP_SW = 9, OP_SD = 10;

   always #5 clk = ~clk;

   mem_access_unit #(.XLEN(64)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .regM_i_valid           (regM_i_valid),
      .regM_i_load_store_info (regM_i_load_store_info),
      .regM_i_alu_result      (regM_i_alu_result),
      .regM_i_regdata2        (regM_i_regdata2),
      .dmem_req_valid         (dmem_req_valid),
      .dmem_req_ready         (dmem_req_ready),
      .dmem_req_addr          (dmem_req_addr),
      .dmem_req_wen           (dmem_req_wen),
      .dmem_req_wdata         (dmem_req_wdata),
      .dmem_req_wstrb         (dmem_req_wstrb),
      .dmem_resp_valid        (dmem_resp_valid),
      .dmem_resp_rdata        (dmem_resp_rdata),
      .memory_o_rdata         (memory_o_rdata),
      .memory_o_done          (memory_o_done),
      .memory_o_stall         (memory_o_stall),
      .memory_o_misalign      (memory_o_misalign)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int op_size(input int op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_LWU, OP_SW: return 4;
         default:              return 8;
      endcase
   endfunction

   // Byte-array model of a load: pick bytes, then extend for signed kinds
   function automatic logic [63:0] model_load(input int op, input logic [2:0] off,
                                              input logic [63:0] mem);
      logic [7:0]  b [8];
      logic [63:0] r;
      int          n;
      int          o;
      n = op_size(op);
      o = int'(off);
      r = '0;
      for (int i = 0; i < 8; i++) b[i] = mem[8*i +: 8];
      for (int i = 0; i < n; i++) r[8*i +: 8] = b[o+i];
      if (op <= OP_LW && r[8*n-1])
         for (int i = 8*n; i < 64; i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic drive_op(input int op, input logic [63:0] addr, input logic [63:0] sdata);
      logic [10:0] one;
      one = 11'd1;
      regM_i_valid           = 1'b1;
      regM_i_load_store_info = one << op;
      regM_i_alu_result      = addr;
      regM_i_regdata2        = sdata;
   endtask

   task automatic idle_inputs();
      regM_i_valid           = 1'b0;
      regM_i_load_store_info = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_req(input string name, input exp_t e);
      chk({name, " req_valid"}, dmem_req_valid, 1);
      chk({name, " req_addr"},  dmem_req_addr,  e.addr);
      chk({name, " req_wen"},   dmem_req_wen,   e.wen);
      chk({name, " req_wdata"}, dmem_req_wdata, e.wdata);
      chk({name, " req_wstrb"}, dmem_req_wstrb, e.wstrb);
      chk({name, " stall_req"}, memory_o_stall, 1);
   endtask

   // One aligned access: push expectation, run the bus side, pop at done
   task automatic do_access(input string name, input int op, input logic [63:0] addr,
                            input logic [63:0] sdata, input logic [63:0] mem,
                            input int ready_delay, input bit resp_early);
      exp_t e;
      exp_t got;
      bit   st;
      int   n;
      int   cyc;
      logic [2:0] off;
      st  = (op >= OP_SB);
      n   = op_size(op);
      off = addr[2:0];
      e.addr  = {addr[63:3], 3'b000};
      e.wen   = st;
      e.wdata = st ? (sdata << (8 * int'(off))) : '0;
      e.wstrb = '0;
      if (st) for (int i = 0; i < n; i++) e.wstrb[int'(off) + i] = 1'b1;
      e.rdata = st ? '0 : model_load(op, off, mem);
      e.lat   = (st ? 2 : 3) + ready_delay;
      exp_q.push_back(e);

      drive_op(op, addr, sdata);
      #1;
      chk({name, " stall_entry"}, memory_o_stall, 1);
      cyc = 0;
      step(); cyc++;
      for (int k = 0; k < ready_delay; k++) begin
         chk_req(name, e);
         step(); cyc++;
      end
      dmem_req_ready = 1'b1;
      if (resp_early) begin
         dmem_resp_valid = 1'b1;
         dmem_resp_rdata = ~mem;
      end
      #1;
      chk_req(name, e);
      step(); cyc++;
      dmem_req_ready  = 1'b0;
      dmem_resp_valid = 1'b0;
      if (!st) begin
         chk({name, " stall_resp"}, memory_o_stall, 1);
         chk({name, " done_early"}, memory_o_done, 0);
         dmem_resp_valid = 1'b1;
         dmem_resp_rdata = mem;
         step(); cyc++;
         dmem_resp_valid = 1'b0;
         dmem_resp_rdata = '0;
      end
      for (int k = 0; k < 4 && memory_o_done !== 1'b1; k++) begin
         step(); cyc++;
      end
      chk({name, " done"}, memory_o_done, 1);
      if (exp_q.size() > 0) begin
         got = exp_q.pop_front();
         if (memory_o_done === 1'b1) begin
            chk({name, " latency"}, 64'(cyc), 64'(got.lat));
            if (!st) chk({name, " rdata"}, memory_o_rdata, got.rdata);
            chk({name, " stall_done"}, memory_o_stall, 0);
         end
      end
      idle_inputs();
      step();
      chk({name, " done_drop"}, memory_o_done, 0);
      $display("access %s addr=%h latency=%0d", name, addr, cyc);
   endtask

   // Misaligned access: one-cycle pulse, no bus request, no stall
   task automatic do_misalign(input string name, input int op, input logic [63:0] addr);
      drive_op(op, addr, 64'h1234);
      #1;
      chk({name, " stall"}, memory_o_stall, 0);
      step();
      idle_inputs();
      #1;
      chk({name, " misalign"},  memory_o_misalign, 1);
      chk({name, " req_valid"}, dmem_req_valid, 0);
      step();
      chk({name, " misalign_drop"}, memory_o_misalign, 0);
      chk({name, " req_valid2"},    dmem_req_valid, 0);
      $display("misalign %s addr=%h", name, addr);
   endtask

   initial begin
      rst             = 1'b0;
      regM_i_valid    = 1'b0;
      regM_i_load_store_info = '0;
      regM_i_alu_result = '0;
      regM_i_regdata2 = '0;
      dmem_req_ready  = 1'b0;
      dmem_resp_valid = 1'b0;
      dmem_resp_rdata = '0;
      #1;
      chk("reset req_valid", dmem_req_valid, 0);
      chk("reset done",      memory_o_done, 0);
      chk("reset stall",     memory_o_stall, 0);
      chk("reset misalign",  memory_o_misalign, 0);
      chk("reset rdata",     memory_o_rdata, 0);
      step(); step();
      rst = 1'b1;
      step();

      // Valid slot without a memory op passes straight through
      regM_i_valid = 1'b1;
      #1;
      chk("nop stall", memory_o_stall, 0);
      step();
      chk("nop req_valid", dmem_req_valid, 0);
      regM_i_valid = 1'b0;

      do_access("lb",  OP_LB,  64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 1'b0);
      do_access("lhu", OP_LHU, 64'h1006, 64'h0, 64'hBEEF_0000_0000_0000, 0, 1'b1);
      do_access("sw",  OP_SW,  64'h1004, 64'hDEADBEEF, 64'h0, 0, 1'b0);
      do_access("sd",  OP_SD,  64'h1010, 64'h0123_4567_89AB_CDEF, 64'h0, 3, 1'b0);
      do_access("lw",  OP_LW,  64'h1104, 64'h0, 64'h8765_4321_0000_0000, 1, 1'b0);
      do_access("lwu", OP_LWU, 64'h1104, 64'h0, 64'h8765_4321_0000_0000, 0, 1'b0);
      do_access("lh",  OP_LH,  64'h1002, 64'h0, 64'h0000_0000_9ABC_0000, 0, 1'b0);
      do_access("lbu", OP_LBU, 64'h1007, 64'h0, 64'hF100_0000_0000_0000, 0, 1'b0);
      do_access("sb",  OP_SB,  64'h1005, 64'hA5, 64'h0, 0, 1'b0);
      do_access("sh",  OP_SH,  64'h1006, 64'hCAFE, 64'h0, 2, 1'b0);

      do_misalign("lw_mis", OP_LW, 64'h1002);
      do_misalign("lh_mis", OP_LH, 64'h1001);
      do_misalign("sd_mis", OP_SD, 64'h1004);

      // Reset while waiting for the read response
      drive_op(OP_LD, 64'h2000, 64'h0);
      step();
      dmem_req_ready = 1'b1;
      step();
      dmem_req_ready = 1'b0;
      idle_inputs();
      chk("rst_mid stall_before", memory_o_stall, 1);
      rst = 1'b0;
      #1;
      chk("rst_mid req_valid", dmem_req_valid, 0);
      chk("rst_mid stall",     memory_o_stall, 0);
      chk("rst_mid done",      memory_o_done, 0);
      chk("rst_mid rdata",     memory_o_rdata, 0);
      chk("rst_mid req_addr",  dmem_req_addr, 0);
      chk("rst_mid wstrb",     dmem_req_wstrb, 0);
      step();
      rst = 1'b1;
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = 64'hFFFF_0000_FFFF_0000;
      step();
      dmem_resp_valid = 1'b0;
      chk("rst_mid late_done", memory_o_done, 0);
      chk("rst_mid late_stall", memory_o_stall, 0);
      step();
      chk("rst_mid late_done2", memory_o_done, 0);
      chk("rst_mid late_rdata", memory_o_rdata, 0);
      $display("reset mid-access checked");

      do_access("ld", OP_LD, 64'h2008, 64'h0, 64'h0011_2233_4455_6677, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
